// File: rtl/ws281x_pkg.sv
// Shared types and constants for the WS281x receive path.
package ws281x_pkg;
    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    localparam int HIGH_W = 8;
    localparam int LOW_W  = 16;
    localparam logic [HIGH_W-1:0] HIGH_MAX = 8'd255;
endpackage

// File: rtl/ws281x_sync_edge.sv
// Two-flop synchronizer for an asynchronous line, plus a registered copy for rise/fall detection.
module ws281x_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/ws281x_decode.sv
// WS281x line decoder: measures high pulses, assembles MSB-first bytes, detects the latch gap.
module ws281x_decode
    import ws281x_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int GLITCH_CNT = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              ws281x_code_in,
    input  logic [7:0]        thr_cnt_in,
    input  logic [15:0]       rst_cnt_in,
    output logic              rx_valid_out,
    output logic [ADDR_W-1:0] rx_addr_out,
    output logic [7:0]        rx_data_out,
    output logic              frame_done_out,
    output logic [ADDR_W:0]   byte_cnt_out,
    output logic              err_out
);
    localparam logic [HIGH_W-1:0] GLITCH = HIGH_W'(GLITCH_CNT);

    logic level, rise, fall;

    ws281x_sync_edge u_sync (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .din   (ws281x_code_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    state_t              state, state_nx;
    logic [HIGH_W-1:0]   high_cnt, high_nx;
    logic [LOW_W-1:0]    low_cnt, low_nx, rst_eff;
    logic [2:0]          bit_cnt, bit_nx;
    logic [7:0]          shreg, sh_nx, sh_shift;
    logic [ADDR_W:0]     addr, addr_nx, bc_nx;
    logic [ADDR_W-1:0]   rxa_nx;
    logic [7:0]          rxd_nx;
    logic                err_nx, valid_nx, done_nx, bit_val;

    assign rst_eff  = (rst_cnt_in == '0) ? 16'd1 : rst_cnt_in;
    assign bit_val  = high_cnt > thr_cnt_in;
    assign sh_shift = {shreg[6:0], bit_val};

    always_comb begin
        state_nx = state;
        high_nx  = high_cnt;
        low_nx   = low_cnt;
        bit_nx   = bit_cnt;
        sh_nx    = shreg;
        addr_nx  = addr;
        err_nx   = err_out;
        valid_nx = 1'b0;
        rxa_nx   = rx_addr_out;
        rxd_nx   = rx_data_out;
        done_nx  = 1'b0;
        bc_nx    = byte_cnt_out;
        case (state)
            SYNC: begin
                if (level) begin
                    low_nx = '0;
                end else if ((17'(low_cnt) + 17'd1) >= 17'(rst_eff)) begin
                    state_nx = IDLE;
                    low_nx   = '0;
                end else begin
                    low_nx = low_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (rise) begin
                    err_nx   = 1'b0;
                    bit_nx   = '0;
                    addr_nx  = '0;
                    high_nx  = 8'd1;
                    state_nx = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nx = LOW;
                    low_nx   = 16'd1;
                    if (high_cnt >= GLITCH) begin
                        sh_nx  = sh_shift;
                        bit_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // addr MSB set means the frame buffer is full
                            if (!addr[ADDR_W]) begin
                                valid_nx = 1'b1;
                                rxd_nx   = sh_shift;
                                rxa_nx   = addr[ADDR_W-1:0];
                                addr_nx  = addr + {{ADDR_W{1'b0}}, 1'b1};
                            end else begin
                                err_nx = 1'b1;
                            end
                        end
                    end
                end else if (high_cnt == HIGH_MAX) begin
                    err_nx   = 1'b1;
                    low_nx   = '0;
                    state_nx = SYNC;
                end else begin
                    high_nx = high_cnt + 8'd1;
                end
            end
            LOW: begin
                // a rise takes priority over the gap reaching its length
                if (rise) begin
                    high_nx  = 8'd1;
                    state_nx = HIGH;
                end else if (low_cnt >= rst_eff) begin
                    done_nx  = 1'b1;
                    bc_nx    = addr;
                    if (bit_cnt != 3'd0) err_nx = 1'b1;
                    bit_nx   = '0;
                    state_nx = IDLE;
                end else if (low_cnt != '1) begin
                    low_nx = low_cnt + 16'd1;
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= SYNC;
            high_cnt       <= '0;
            low_cnt        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            addr           <= '0;
            err_out        <= 1'b0;
            rx_valid_out   <= 1'b0;
            rx_addr_out    <= '0;
            rx_data_out    <= '0;
            frame_done_out <= 1'b0;
            byte_cnt_out   <= '0;
        end else begin
            state          <= state_nx;
            high_cnt       <= high_nx;
            low_cnt        <= low_nx;
            bit_cnt        <= bit_nx;
            shreg          <= sh_nx;
            addr           <= addr_nx;
            err_out        <= err_nx;
            rx_valid_out   <= valid_nx;
            rx_addr_out    <= rxa_nx;
            rx_data_out    <= rxd_nx;
            frame_done_out <= done_nx;
            byte_cnt_out   <= bc_nx;
        end
    end
endmodule
